duty_ratio_bcd: RTL and testbench

- Downstream stage of the duty-cycle measurement counters.
- Consumes the latched high-time count tH and period count T. Computes duty cycle in per-mille, tH*1000/T, with a multi-cycle restoring divider.
- Converts the result to four BCD digits q4..q1 via sequential double-dabble, for the display scanner. Display format is q4 q3 q2 . q1 %.

---
 rtl/duty_ratio_bcd_if.sv | 19 +
 rtl/duty_ratio_bcd.sv | 173 +++++++++++++++++
 tb/tb_duty_ratio_bcd.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/duty_ratio_bcd_if.sv
// Request/result bundle between the duty-cycle counters, the ratio stage and the display scanner.
interface duty_ratio_bcd_if #(
  parameter int W = 10
);
  logic         start;
  logic [W-1:0] tH;
  logic [W-1:0] T;
  logic         busy;
  logic         done;
  logic [3:0]   q4;
  logic [3:0]   q3;
  logic [3:0]   q2;
  logic [3:0]   q1;
  logic         err;
  logic         ovf;

  modport master (output start, tH, T, input busy, done, q4, q3, q2, q1, err, ovf);
  modport slave  (input start, tH, T, output busy, done, q4, q3, q2, q1, err, ovf);
endinterface

// File: rtl/duty_ratio_bcd.sv
// Duty cycle in per-mille (tH*1000/T) by a 2*W-step restoring divider, then 10-step double-dabble to BCD.
// Define DUTY_ROUND_EN to round the result half-up instead of truncating it.
module duty_ratio_bcd #(
  parameter int W = 10
) (
  input  logic            clk,
  input  logic            clr,
  duty_ratio_bcd_if.slave bus
);

  localparam int PW    = W + 10;
  localparam int N_DIV = 2 * W;
  localparam int CW    = $clog2(((N_DIV > 10) ? N_DIV : 10) + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(N_DIV - 1);
  localparam logic [CW-1:0] BCD_LAST = CW'(9);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_BCD, S_OUT} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  th_q, th_d;
  logic [W-1:0]  t_q, t_d;
  logic [PW-1:0] dvd_q, dvd_d;
  logic [PW-1:0] quo_q, quo_d;
  logic [W:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_n_q, err_n_d;
  logic          ovf_n_q, ovf_n_d;
  logic [25:0]   dd_q, dd_d;
  logic [15:0]   dig_q, dig_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;

  logic [PW-1:0] th_ext;
  logic [PW-1:0] prod;
  logic [W+1:0]  rem_sh;
  logic [W:0]    rem_sub;
  logic          fits;
  logic [PW-1:0] quo_nx;
  logic [9:0]    bin_sel;
  logic [25:0]   dd_adj;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    th_d    = th_q;
    t_d     = t_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_n_d = err_n_q;
    ovf_n_d = ovf_n_q;
    dd_d    = dd_q;
    dig_d   = dig_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    // tH*1000 built from shifts: 1024 - 16 - 8.
    th_ext = PW'(th_q);
    prod   = (th_ext << 10) - (th_ext << 4) - (th_ext << 3);
`ifdef DUTY_ROUND_EN
    prod   = prod + PW'(t_q >> 1);
`endif

    rem_sh  = {rem_q, dvd_q[PW-1]};
    fits    = rem_sh >= (W+2)'(t_q);
    rem_sub = rem_sh[W:0] - {1'b0, t_q};
    quo_nx  = {quo_q[PW-2:0], fits};

    // Divide-by-zero wins over the clamp; the raw quotient is meaningless in both cases.
    if (err_n_q)      bin_sel = 10'd0;
    else if (ovf_n_q) bin_sel = 10'd1000;
    else              bin_sel = quo_nx[9:0];

    dd_adj = dd_q;
    for (int i = 0; i < 4; i++) begin
      if (dd_adj[10+4*i +: 4] >= 4'd5) dd_adj[10+4*i +: 4] = dd_adj[10+4*i +: 4] + 4'd3;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          th_d    = bus.tH;
          t_d     = bus.T;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dvd_d   = prod;
        quo_d   = '0;
        rem_d   = '0;
        cnt_d   = '0;
        err_n_d = (t_q == '0);
        ovf_n_d = (t_q != '0) && (th_q > t_q);
        state_d = S_DIV;
      end
      S_DIV: begin
        dvd_d = {dvd_q[PW-2:0], 1'b0};
        rem_d = fits ? rem_sub : rem_sh[W:0];
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          dd_d    = {16'd0, bin_sel};
          state_d = S_BCD;
        end
      end
      S_BCD: begin
        dd_d  = dd_adj << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BCD_LAST) begin
          cnt_d   = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        dig_d   = dd_q[25:10];
        err_d   = err_n_q;
        ovf_d   = ovf_n_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge value of its peers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      th_q    <= '0;
      t_q     <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_n_q <= 1'b0;
      ovf_n_q <= 1'b0;
      dd_q    <= '0;
      dig_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      th_q    <= th_d;
      t_q     <= t_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_n_q <= err_n_d;
      ovf_n_q <= ovf_n_d;
      dd_q    <= dd_d;
      dig_q   <= dig_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.q4   = dig_q[15:12];
  assign bus.q3   = dig_q[11:8];
  assign bus.q2   = dig_q[7:4];
  assign bus.q1   = dig_q[3:0];
  assign bus.err  = err_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_duty_ratio_bcd.sv
// Scoreboard bench for duty_ratio_bcd: stimulus pushes model results, a monitor pops them on done.
module tb_duty_ratio_bcd;

  localparam int W = 10;

  typedef struct packed {
    logic [15:0] dig;
    logic        err;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic clr;

  duty_ratio_bcd_if #(.W(W)) bus ();

  duty_ratio_bcd #(.W(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   last_a = -100;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  exp_t held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: per-mille ratio from plain integer arithmetic, then decimal digits.
  function automatic exp_t model(input int th, input int t);
    exp_t e;
    int   v;
    e.err = (t == 0);
    e.ovf = (t != 0) && (th > t);
    if (e.err)      v = 0;
    else if (e.ovf) v = 1000;
    else begin
`ifdef DUTY_ROUND_EN
      v = (th * 1000 + t / 2) / t;
`else
      v = (th * 1000) / t;
`endif
    end
    e.dig[15:12] = 4'(v / 1000);
    e.dig[11:8]  = 4'((v / 100) % 10);
    e.dig[7:4]   = 4'((v / 10) % 10);
    e.dig[3:0]   = 4'(v % 10);
    return e;
  endfunction

  // Drives one start pulse; acceptance is decided from the bench's own notion of when the block is idle.
  task automatic issue(input int th, input int t);
    @(negedge clk);
    bus.start = 1'b1;
    bus.tH    = W'(th);
    bus.T     = W'(t);
    if (cyc + 1 >= last_a + 33) begin
      last_a = cyc + 1;
      sb.push_back(model(th, t));
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.tH    = W'($urandom);
    bus.T     = W'($urandom);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // gap = 0 asserts start during the done cycle, i.e. back-to-back.
  task automatic next_txn(input int th, input int t, input int gap);
    wait_cyc(last_a + 31 + gap);
    issue(th, t);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, {bus.q4, bus.q3, bus.q2, bus.q1}, 32'd0);
    check({tag, "_err"},    bus.err,  32'd0);
    check({tag, "_ovf"},    bus.ovf,  32'd0);
    check({tag, "_busy"},   bus.busy, 32'd0);
    check({tag, "_done"},   bus.done, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    clr    = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (3) @(negedge clk);
    check_zero("rst_hold");
    clr    = 1'b1;
    last_a = -100;
    sb.delete();
    held   = '0;
    mon_en = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      check("busy", bus.busy, 32'((cyc >= last_a) && (cyc <= last_a + 31)));
      check("done", bus.done, 32'(cyc == last_a + 32));
      if (bus.done) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) held = sb.pop_front();
      end
      check("digits", {bus.q4, bus.q3, bus.q2, bus.q1}, held.dig);
      check("err",    bus.err, held.err);
      check("ovf",    bus.ovf, held.ovf);
    end
  end

  int d_th [8] = '{100, 2, 1, 1023, 600,   0, 5, 7};
  int d_t  [8] = '{500, 3, 3, 1023, 500, 500, 0, 9};
  int d_gap[8] = '{  2, 0, 0,    1,   0,   3, 0, 0};

  initial begin
    clr       = 1'b0;
    bus.start = 1'b0;
    bus.tH    = '0;
    bus.T     = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    clr    = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) next_txn(d_th[i], d_t[i], d_gap[i]);

    // Extra starts while busy must be dropped.
    next_txn(250, 1000, 2);
    repeat (5) @(negedge clk);
    issue(999, 1);
    repeat (10) @(negedge clk);
    issue(3, 7);

    // Reset in the middle of the divide phase.
    next_txn(100, 500, 1);
    repeat (8) @(negedge clk);
    do_reset();

    for (int i = 0; i < 40; i++) begin
      int t, th, mode;
      t    = $urandom_range(0, 1023);
      mode = $urandom_range(0, 9);
      if (mode == 0)                 t  = 0;
      if (mode == 0)                 th = $urandom_range(0, 1023);
      else if (mode == 1 && t < 1023) th = $urandom_range(t + 1, 1023);
      else                           th = $urandom_range(0, t);
      next_txn(th, t, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        issue($urandom_range(0, 1023), $urandom_range(0, 1023));
      end
    end

    wait_cyc(last_a + 40);
    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
